// File: rtl/fetch_buffer.sv
// Dual-slot instruction buffer: circular FIFO of {inst, pc} entries fed by
// masked two-instruction fetch blocks and drained two-at-a-time by decode.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mem_valid_i,
  input  logic [31:0]                mem_pc_i,
  input  logic [63:0]                mem_data_i,
  input  logic [1:0]                 mem_mask_i,
  output logic                       mem_ready_o,
  input  logic                       flush_i,
  input  logic                       stall_i,
  output logic [31:0]                inst0_o,
  output logic [31:0]                pc0_o,
  output logic                       was_fetched0_o,
  output logic [31:0]                inst1_o,
  output logic [31:0]                pc1_o,
  output logic                       was_fetched1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          accept;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic          wr0_en, wr1_en;
  logic [31:0]   wr0_inst, wr0_pc;
  logic [PW-1:0] head_p1;

  // Handshake: a block transfers on a rising edge where mem_valid_i and
  // mem_ready_o are both high and flush_i is low; the producer holds all
  // mem_* inputs stable until then. mem_ready_o depends on registered count
  // only, so a same-cycle pop never opens room for a push.
  assign mem_ready_o = (count_q <= CW'(DEPTH - 2));
  assign accept      = mem_valid_i && mem_ready_o && !flush_i;

  // Low half lands at tail; a lone high half is packed down into tail too.
  assign wr0_en   = accept && (mem_mask_i != 2'b00);
  assign wr1_en   = accept && (mem_mask_i == 2'b11);
  assign wr0_inst = mem_mask_i[0] ? mem_data_i[31:0] : mem_data_i[63:32];
  assign wr0_pc   = mem_mask_i[0] ? mem_pc_i : (mem_pc_i + 32'd4);

  always_comb begin
    push_cnt = '0;
    if (accept) push_cnt = CW'(mem_mask_i[0]) + CW'(mem_mask_i[1]);
  end

  always_comb begin
    pop_cnt = '0;
    if (!stall_i && !flush_i) pop_cnt = (count_q >= CW'(2)) ? CW'(2) : count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop_cnt);
      tail_q  <= tail_q + PW'(push_cnt);
      count_q <= count_q + push_cnt - pop_cnt;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (wr0_en) begin
      inst_q[tail_q] <= wr0_inst;
      pc_q[tail_q]   <= wr0_pc;
    end
    if (wr1_en) begin
      inst_q[tail_q + PW'(1)] <= mem_data_i[63:32];
      pc_q[tail_q + PW'(1)]   <= mem_pc_i + 32'd4;
    end
  end

  assign head_p1        = head_q + PW'(1);
  assign was_fetched0_o = (count_q >= CW'(1));
  assign was_fetched1_o = (count_q >= CW'(2));
  assign inst0_o        = was_fetched0_o ? inst_q[head_q]  : 32'd0;
  assign pc0_o          = was_fetched0_o ? pc_q[head_q]    : 32'd0;
  assign inst1_o        = was_fetched1_o ? inst_q[head_p1] : 32'd0;
  assign pc1_o          = was_fetched1_o ? pc_q[head_p1]   : 32'd0;
  assign count_o        = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, full/masked blocks, back-pressure,
// wrap-around streaming, flush priority and asynchronous reset.
module tb_fetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [63:0] mem_data_i;
  logic [1:0]  mem_mask_i;
  logic        mem_ready_o;
  logic        flush_i;
  logic        stall_i;
  logic [31:0] inst0_o, pc0_o, inst1_o, pc1_o;
  logic        was_fetched0_o, was_fetched1_o;
  logic [2:0]  count_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_buffer #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_data_i(mem_data_i),
    .mem_mask_i(mem_mask_i), .mem_ready_o(mem_ready_o),
    .flush_i(flush_i), .stall_i(stall_i),
    .inst0_o(inst0_o), .pc0_o(pc0_o), .was_fetched0_o(was_fetched0_o),
    .inst1_o(inst1_o), .pc1_o(pc1_o), .was_fetched1_o(was_fetched1_o),
    .count_o(count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_block(input logic [31:0] pc, input logic [1:0] mask);
    mem_valid_i = 1'b1;
    mem_pc_i    = pc;
    mem_data_i  = {32'hA000_0000 | (pc + 32'd4), 32'hA000_0000 | pc};
    mem_mask_i  = mask;
  endtask

  task automatic idle_mem();
    mem_valid_i = 1'b0;
    mem_mask_i  = 2'b00;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; idle_mem(); flush_i = 1'b0; stall_i = 1'b0;
    mem_pc_i = '0; mem_data_i = '0;
    #2;
    total_cnt++;
    if ({mem_ready_o, was_fetched0_o, was_fetched1_o, count_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      $display("FAIL reset_flags: got rdy=%b wf0=%b wf1=%b cnt=%0d want 1 0 0 0",
               mem_ready_o, was_fetched0_o, was_fetched1_o, count_o);
    end else pass_cnt++;
    total_cnt++;
    if ({inst0_o, pc0_o, inst1_o, pc1_o} !== 128'd0) begin
      $display("FAIL reset_slots: got %h %h %h %h want all zero", inst0_o, pc0_o, inst1_o, pc1_o);
    end else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle();
  endtask

  task automatic test_full_block();
    drive_block(32'h100, 2'b11);
    mem_data_i = {32'h0020_8133, 32'h0010_0093};
    cycle();
    idle_mem();
    total_cnt++;
    if ({inst0_o, pc0_o, inst1_o, pc1_o} !== {32'h0010_0093, 32'h100, 32'h0020_8133, 32'h104}) begin
      $display("FAIL full_block_slots: got %h@%h %h@%h want 00100093@100 00208133@104",
               inst0_o, pc0_o, inst1_o, pc1_o);
    end else pass_cnt++;
    total_cnt++;
    if ({was_fetched0_o, was_fetched1_o, count_o} !== {1'b1, 1'b1, 3'd2}) begin
      $display("FAIL full_block_flags: got wf0=%b wf1=%b cnt=%0d want 1 1 2",
               was_fetched0_o, was_fetched1_o, count_o);
    end else pass_cnt++;
    cycle();
    total_cnt++;
    if ({was_fetched0_o, was_fetched1_o, count_o, pc0_o} !== {1'b0, 1'b0, 3'd0, 32'd0}) begin
      $display("FAIL full_block_drain: got wf0=%b wf1=%b cnt=%0d pc0=%h want 0 0 0 0",
               was_fetched0_o, was_fetched1_o, count_o, pc0_o);
    end else pass_cnt++;
  endtask

  task automatic test_masked();
    stall_i = 1'b1;
    drive_block(32'h200, 2'b10);
    cycle();
    idle_mem();
    total_cnt++;
    if ({was_fetched0_o, pc0_o, inst0_o, count_o} !== {1'b1, 32'h204, 32'hA000_0204, 3'd1}) begin
      $display("FAIL masked_slot0: got wf0=%b pc0=%h inst0=%h cnt=%0d want 1 204 a0000204 1",
               was_fetched0_o, pc0_o, inst0_o, count_o);
    end else pass_cnt++;
    total_cnt++;
    if ({was_fetched1_o, inst1_o, pc1_o} !== {1'b0, 32'd0, 32'd0}) begin
      $display("FAIL masked_slot1: got wf1=%b inst1=%h pc1=%h want 0 0 0",
               was_fetched1_o, inst1_o, pc1_o);
    end else pass_cnt++;
    drive_block(32'h300, 2'b00);
    cycle();
    idle_mem();
    total_cnt++;
    if ({count_o, pc0_o} !== {3'd1, 32'h204}) begin
      $display("FAIL empty_mask: got cnt=%0d pc0=%h want 1 204", count_o, pc0_o);
    end else pass_cnt++;
    stall_i = 1'b0;
    cycle();
    total_cnt++;
    if (count_o !== 3'd0) $display("FAIL masked_drain: got cnt=%0d want 0", count_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    stall_i = 1'b1;
    drive_block(32'h0, 2'b11);
    cycle();
    drive_block(32'h8, 2'b11);
    cycle();
    drive_block(32'h10, 2'b11);
    total_cnt++;
    if ({count_o, mem_ready_o, pc0_o, pc1_o} !== {3'd4, 1'b0, 32'h0, 32'h4}) begin
      $display("FAIL full_state: got cnt=%0d rdy=%b pc0=%h pc1=%h want 4 0 0 4",
               count_o, mem_ready_o, pc0_o, pc1_o);
    end else pass_cnt++;
    cycle();
    total_cnt++;
    if ({count_o, pc0_o} !== {3'd4, 32'h0}) begin
      $display("FAIL full_hold: got cnt=%0d pc0=%h want 4 0", count_o, pc0_o);
    end else pass_cnt++;
    stall_i = 1'b0;
    cycle();
    total_cnt++;
    if ({count_o, mem_ready_o, pc0_o, pc1_o} !== {3'd2, 1'b1, 32'h8, 32'hC}) begin
      $display("FAIL release_pop1: got cnt=%0d rdy=%b pc0=%h pc1=%h want 2 1 8 c",
               count_o, mem_ready_o, pc0_o, pc1_o);
    end else pass_cnt++;
    cycle();
    idle_mem();
    total_cnt++;
    if ({count_o, pc0_o, pc1_o, inst1_o} !== {3'd2, 32'h10, 32'h14, 32'hA000_0014}) begin
      $display("FAIL release_accept: got cnt=%0d pc0=%h pc1=%h inst1=%h want 2 10 14 a0000014",
               count_o, pc0_o, pc1_o, inst1_o);
    end else pass_cnt++;
    cycle();
    total_cnt++;
    if (count_o !== 3'd0) $display("FAIL backpressure_drain: got cnt=%0d want 0", count_o);
    else pass_cnt++;
  endtask

  // Ten streamed blocks: every cycle both slots must carry the next two PCs.
  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    int bad = 0;
    stall_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_block(32'h1000 + 32'(k) * 32'd8, 2'b11);
      exp_q.push_back(32'h1000 + 32'(k) * 32'd8);
      exp_q.push_back(32'h1004 + 32'(k) * 32'd8);
      cycle();
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      if ({was_fetched0_o, was_fetched1_o, pc0_o, pc1_o, inst0_o} !==
          {1'b1, 1'b1, e0, e1, 32'hA000_0000 | e0}) begin
        $display("FAIL stream_block%0d: got wf=%b%b pc0=%h pc1=%h inst0=%h want 11 %h %h a%h",
                 k, was_fetched0_o, was_fetched1_o, pc0_o, pc1_o, inst0_o, e0, e1, e0[27:0]);
        bad++;
      end
    end
    idle_mem();
    total_cnt++;
    if (bad != 0) $display("FAIL stream_summary: got %0d bad blocks want 0", bad);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({count_o, exp_q.size() == 0} !== {3'd0, 1'b1}) begin
      $display("FAIL stream_drain: got cnt=%0d want 0", count_o);
    end else pass_cnt++;
  endtask

  task automatic test_flush();
    stall_i = 1'b1;
    drive_block(32'h300, 2'b11);
    cycle();
    drive_block(32'h308, 2'b01);
    cycle();
    total_cnt++;
    if (count_o !== 3'd3) $display("FAIL flush_setup: got cnt=%0d want 3", count_o);
    else pass_cnt++;
    drive_block(32'h400, 2'b11);
    flush_i = 1'b1;
    stall_i = 1'b0;
    cycle();
    flush_i = 1'b0;
    idle_mem();
    total_cnt++;
    if ({count_o, was_fetched0_o, was_fetched1_o, mem_ready_o, pc0_o} !== {3'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
      $display("FAIL flush_state: got cnt=%0d wf=%b%b rdy=%b pc0=%h want 0 00 1 0",
               count_o, was_fetched0_o, was_fetched1_o, mem_ready_o, pc0_o);
    end else pass_cnt++;
    drive_block(32'h500, 2'b01);
    cycle();
    idle_mem();
    total_cnt++;
    if ({count_o, pc0_o, was_fetched1_o} !== {3'd1, 32'h500, 1'b0}) begin
      $display("FAIL post_flush_push: got cnt=%0d pc0=%h wf1=%b want 1 500 0",
               count_o, pc0_o, was_fetched1_o);
    end else pass_cnt++;
    cycle();
  endtask

  task automatic test_async_reset();
    stall_i = 1'b1;
    drive_block(32'h600, 2'b11);
    cycle();
    idle_mem();
    total_cnt++;
    if (count_o !== 3'd2) $display("FAIL areset_setup: got cnt=%0d want 2", count_o);
    else pass_cnt++;
    #1 rst_ni = 1'b0;
    #1;
    total_cnt++;
    if ({count_o, was_fetched0_o, was_fetched1_o, mem_ready_o, pc0_o, inst1_o} !==
        {3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0}) begin
      $display("FAIL areset_immediate: got cnt=%0d wf=%b%b rdy=%b pc0=%h inst1=%h want 0 00 1 0 0",
               count_o, was_fetched0_o, was_fetched1_o, mem_ready_o, pc0_o, inst1_o);
    end else pass_cnt++;
    @(negedge clk_i);
    rst_ni  = 1'b1;
    stall_i = 1'b0;
    cycle();
    total_cnt++;
    if (count_o !== 3'd0) $display("FAIL areset_after: got cnt=%0d want 0", count_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_masked();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction buffer between the instruction-memory fetch port and the two decoders of the dual-issue front end. It accepts fetch responses of up to two 32-bit instructions per cycle and stores them in program order in a circular FIFO. Each cycle it presents the two oldest instructions, with PCs and per-slot `was_fetched` flags, to decoder slots 0 and 1. It also handles decode stalls, pipeline flushes and partial (masked) fetch blocks.

## Interface
- `DEPTH`, 4: number of single-instruction entries; must be a power of two and at least 4.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `mem_valid_i` in 1: fetch response valid; the producer holds all `mem_*` inputs stable until accepted.
- `mem_pc_i` in 32: address of the low instruction of the block.
- `mem_data_i` in 64: `[31:0]` is the instruction at `mem_pc_i`; `[63:32]` is the instruction at `mem_pc_i+4`.
- `mem_mask_i` in 2: bit0 marks the low half valid, bit1 the high half.
- `mem_ready_o` out 1: buffer can accept a block; high when free entries ≥ 2.
- `flush_i` in 1: discard all buffered instructions (redirect).
- `stall_i` in 1: decode cannot consume this cycle.
- `inst0_o` out 32, `pc0_o` out 32, `was_fetched0_o` out 1: slot 0 (oldest entry).
- `inst1_o` out 32, `pc1_o` out 32, `was_fetched1_o` out 1: slot 1 (second-oldest entry).
- `count_o` out clog2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: DEPTH entries of {inst[31:0], pc[31:0]}, plus head pointer, tail pointer and count.
  - Pointers wrap modulo DEPTH.
  - `count_o` ranges from 0 to DEPTH.
- Accept condition: `mem_valid_i && mem_ready_o && !flush_i`.
  - On accept, push the valid halves in order: low half first at `mem_pc_i`, then high half at `mem_pc_i+4`.
  - Pushed count is popcount(`mem_mask_i`), from 0 to 2.
  - Mask `2'b10` pushes only the high half, with pc = `mem_pc_i+4`.
  - Mask `2'b00` is accepted but pushes nothing.
- `mem_ready_o` = (DEPTH − count) ≥ 2, computed from registered count only. It does not depend on same-cycle pops.
- Slot presentation is combinational from storage:
  - `was_fetched0_o` = count ≥ 1.
  - `was_fetched1_o` = count ≥ 2.
  - `inst0_o`/`pc0_o` = entry[head]; `inst1_o`/`pc1_o` = entry[head+1].
  - An output whose `was_fetched` flag is low drives inst = 0 and pc = 0.
- Pop condition: `!stall_i && !flush_i`. Pops min(count, 2) entries, i.e. every presented valid slot is consumed; head advances by the popped amount.
- Simultaneous push and pop:
  - count_next = count + pushed − popped.
  - Pop is based on pre-push count, so there is no bypass from the memory input to the slots.
- Flush has priority over everything:
  - Next cycle, head = tail = 0 and count = 0.
  - Any same-cycle push and pop are discarded.
  - Storage contents need not be cleared.
- Stall: no pop. Slot outputs stay unchanged unless a push changes the count from 0 or 1; newly pushed entries then appear in the empty slots.
- Reset (async assert, sync-safe deassert on clock): head = tail = count = 0.
  - `mem_ready_o` = 1.
  - `was_fetched0_o` = `was_fetched1_o` = 0.
  - `inst*_o` = `pc*_o` = 0, `count_o` = 0.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Push-to-present latency is 1 cycle: an instruction accepted at edge N appears on the slot outputs after edge N, in the cycle following acceptance.
- A pop at edge N shows the next entries after edge N.
- Full throughput: two instructions in and two out per cycle is sustained at steady state when DEPTH ≥ 4.
- `mem_ready_o`, `count_o` and the `was_fetched*_o` flags are functions of registered state only.
- `inst*_o`/`pc*_o` are a read mux of registered state with no input-to-output combinational path.
- Flush takes effect at the next edge. In the flush cycle itself the outputs still show pre-flush contents, and decode must ignore them via `flush_i`.

## Test plan
- Reset, then push block pc=0x100, data={0x00208133, 0x00100093}, mask=11 → next cycle slot0 = (0x00100093, 0x100), slot1 = (0x00208133, 0x104), both `was_fetched` = 1. After one unstalled cycle, count = 0 and both `was_fetched` = 0.
- Push masked block pc=0x200, mask=10 → only slot0 valid, pc0 = 0x204; `was_fetched1_o` = 0, inst1 = 0, pc1 = 0.
- Hold `stall_i` = 1 and push blocks at pc 0x0, 0x8 → count = 4, `mem_ready_o` = 0. A third block held valid is not accepted. Release stall → pops 0x0/0x4, then 0x8/0xC; third block accepted the cycle `mem_ready_o` rises.
- Wrap-around: push/pop continuously for 10 blocks starting at pc 0x1000 → slot PCs increase by 4 with no gaps or duplicates; pointers wrap past DEPTH.
- Flush with count = 3 and a simultaneous valid push → next cycle count = 0, both `was_fetched` = 0, `mem_ready_o` = 1; the pushed block is absent.
- Assert `rst_ni` low mid-stream with count = 2 → outputs return to reset values asynchronously before the next clock edge.
